// File: rtl/diq_pkg.sv
// rtl/diq_pkg.sv - shared opcode constants and instruction field helpers
// Purpose: opcode localparams, field slice helpers and register-usage
//          classification used by the pair checker.
// Ports:   none (package).
package diq_pkg;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;

  function automatic logic [6:0] opcode(input logic [31:0] instr);
    return instr[6:0];
  endfunction

  function automatic logic [4:0] rd(input logic [31:0] instr);
    return instr[11:7];
  endfunction

  function automatic logic [4:0] rs1(input logic [31:0] instr);
    return instr[19:15];
  endfunction

  function automatic logic [4:0] rs2(input logic [31:0] instr);
    return instr[24:20];
  endfunction

  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_R, OP_I, OP_LOAD, OP_LUI, OP_AUIPC, OP_JAL, OP_JALR: return 1'b1;
      default:                                               return 1'b0;
    endcase
  endfunction

  // Anything not known to skip rs1 is treated as reading it (conservative).
  function automatic logic reads_rs1(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL: return 1'b0;
      default:                  return 1'b1;
    endcase
  endfunction

  function automatic logic reads_rs2(input logic [6:0] op);
    case (op)
      OP_R, OP_STORE, OP_BRANCH: return 1'b1;
      default:                   return 1'b0;
    endcase
  endfunction

  function automatic logic is_mem(input logic [6:0] op);
    return (op == OP_LOAD) || (op == OP_STORE);
  endfunction

  function automatic logic is_ctrl(input logic [6:0] op);
    return (op == OP_BRANCH) || (op == OP_JAL) || (op == OP_JALR);
  endfunction

endpackage

// File: rtl/diq_pair_check.sv
// rtl/diq_pair_check.sv - combinational dual-issue compatibility check
// Purpose: decides whether the instruction after the head may issue in
//          slot 2 alongside the head.
// Ports:   instr_head  - older instruction (slot 1 candidate)
//          instr_next  - younger instruction (slot 2 candidate)
//          can_pair    - 1 when the two may issue together
module diq_pair_check (
  input  logic [31:0] instr_head,
  input  logic [31:0] instr_next,
  output logic        can_pair
);
  import diq_pkg::*;

  logic [6:0] op_h, op_n;
  logic [4:0] rd_h, rd_n, rs1_n, rs2_n;
  logic       wr_h, wr_n;
  logic       raw, waw, mem2, ctrl;

  always_comb begin
    op_h  = opcode(instr_head);
    op_n  = opcode(instr_next);
    rd_h  = rd(instr_head);
    rd_n  = rd(instr_next);
    rs1_n = rs1(instr_next);
    rs2_n = rs2(instr_next);
    wr_h  = writes_rd(op_h);
    wr_n  = writes_rd(op_n);

    raw  = wr_h && (rd_h != 5'd0) &&
           ((reads_rs1(op_n) && (rs1_n == rd_h)) ||
            (reads_rs2(op_n) && (rs2_n == rd_h)));
    waw  = wr_h && wr_n && (rd_h != 5'd0) && (rd_h == rd_n);
    mem2 = is_mem(op_h) && is_mem(op_n);
    // A control transfer at the head may redirect, so its successor waits.
    ctrl = is_ctrl(op_h);

    can_pair = !(raw || waw || mem2 || ctrl);
  end

endmodule

// File: rtl/dual_issue_queue.sv
// rtl/dual_issue_queue.sv - instruction buffer with dual-issue slot selection
// Purpose: circular instruction queue accepting up to two pushes per cycle
//          and popping one or two instructions into registered decode slots.
// Ports:   clk, reset (async active-low)
//          in_valid_1/2, in_instr_1/2 - fetch push (instr_1 older)
//          in_ready                   - at least two free entries
//          flush                      - clears queue and slots, drops pushes
//          stall                      - holds slots, no pop
//          out_valid_1/2, out_instr_1/2 - registered slot outputs
//          count                      - occupied entries
// Option:  DIQ_STATS_EN adds pair_cnt / single_cnt issue counters.
module dual_issue_queue #(
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       in_valid_1,
  input  logic                       in_valid_2,
  input  logic [31:0]                in_instr_1,
  input  logic [31:0]                in_instr_2,
  output logic                       in_ready,
  input  logic                       flush,
  input  logic                       stall,
  output logic                       out_valid_1,
  output logic                       out_valid_2,
  output logic [31:0]                out_instr_1,
  output logic [31:0]                out_instr_2,
  output logic [$clog2(DEPTH):0]     count
`ifdef DIQ_STATS_EN
  ,
  output logic [31:0]                pair_cnt,
  output logic [31:0]                single_cnt
`endif
);
  import diq_pkg::*;

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);

  logic [31:0]      mem_q [DEPTH];
  logic [PTR_W-1:0] head_q, head_d, tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             v1_q, v1_d, v2_q, v2_d;
  logic [31:0]      i1_q, i1_d, i2_q, i2_d;

  logic             push_en, push_two, can_pair;
  logic [CNT_W-1:0] push_num, pop_num;
  logic [31:0]      head_instr, next_instr;

  assign head_instr = mem_q[head_q];
  // Pointer arithmetic wraps naturally because DEPTH is a power of two.
  assign next_instr = mem_q[head_q + PTR_ONE];

  diq_pair_check u_pair_check (
    .instr_head (head_instr),
    .instr_next (next_instr),
    .can_pair   (can_pair)
  );

  assign in_ready = (count_q <= CNT_W'(DEPTH - 2));
  assign push_en  = in_ready && in_valid_1 && !flush;
  assign push_two = push_en && in_valid_2;
  assign push_num = push_two ? CNT_W'(2) : (push_en ? CNT_W'(1) : CNT_W'(0));

  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    v1_d    = v1_q;
    v2_d    = v2_q;
    i1_d    = i1_q;
    i2_d    = i2_q;
    pop_num = CNT_W'(0);

    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      v1_d    = 1'b0;
      v2_d    = 1'b0;
      i1_d    = 32'h0;
      i2_d    = 32'h0;
    end else begin
      if (!stall) begin
        v1_d = 1'b0;
        v2_d = 1'b0;
        i1_d = 32'h0;
        i2_d = 32'h0;
        if (count_q != CNT_W'(0)) begin
          v1_d    = 1'b1;
          i1_d    = head_instr;
          pop_num = CNT_W'(1);
          if ((count_q >= CNT_W'(2)) && can_pair) begin
            v2_d    = 1'b1;
            i2_d    = next_instr;
            pop_num = CNT_W'(2);
          end
        end
      end
      head_d  = head_q + PTR_W'(pop_num);
      tail_d  = tail_q + PTR_W'(push_num);
      count_d = count_q + push_num - pop_num;
    end
  end

  // Storage needs no reset: entries are only read while counted as occupied.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[tail_q] <= in_instr_1;
    end
    if (push_two) begin
      mem_q[tail_q + PTR_ONE] <= in_instr_2;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      v1_q    <= 1'b0;
      v2_q    <= 1'b0;
      i1_q    <= 32'h0;
      i2_q    <= 32'h0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      v1_q    <= v1_d;
      v2_q    <= v2_d;
      i1_q    <= i1_d;
      i2_q    <= i2_d;
    end
  end

  assign out_valid_1 = v1_q;
  assign out_valid_2 = v2_q;
  assign out_instr_1 = i1_q;
  assign out_instr_2 = i2_q;
  assign count       = count_q;

`ifdef DIQ_STATS_EN
  logic [31:0] pair_q, pair_d, single_q, single_d;

  always_comb begin
    pair_d   = pair_q;
    single_d = single_q;
    if (flush) begin
      pair_d   = 32'h0;
      single_d = 32'h0;
    end else if (pop_num == CNT_W'(2)) begin
      pair_d   = pair_q + 32'd1;
    end else if (pop_num == CNT_W'(1)) begin
      single_d = single_q + 32'd1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pair_q   <= 32'h0;
      single_q <= 32'h0;
    end else begin
      pair_q   <= pair_d;
      single_q <= single_d;
    end
  end

  assign pair_cnt   = pair_q;
  assign single_cnt = single_q;
`endif

endmodule

// File: tb/tb_dual_issue_queue.sv
// tb/tb_dual_issue_queue.sv - self-checking bench for dual_issue_queue
module tb_dual_issue_queue;

  localparam int DEPTH = 8;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid_1 = 1'b0, in_valid_2 = 1'b0;
  logic [31:0] in_instr_1 = 32'h0, in_instr_2 = 32'h0;
  logic        flush = 1'b0, stall = 1'b0;
  logic        in_ready, out_valid_1, out_valid_2;
  logic [31:0] out_instr_1, out_instr_2;
  logic [3:0]  count;
`ifdef DIQ_STATS_EN
  logic [31:0] pair_cnt, single_cnt;
`endif

  dual_issue_queue #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid_1  (in_valid_1),
    .in_valid_2  (in_valid_2),
    .in_instr_1  (in_instr_1),
    .in_instr_2  (in_instr_2),
    .in_ready    (in_ready),
    .flush       (flush),
    .stall       (stall),
    .out_valid_1 (out_valid_1),
    .out_valid_2 (out_valid_2),
    .out_instr_1 (out_instr_1),
    .out_instr_2 (out_instr_2),
    .count       (count)
`ifdef DIQ_STATS_EN
    ,
    .pair_cnt    (pair_cnt),
    .single_cnt  (single_cnt)
`endif
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nfail = 0;

  // Reference model: a plain queue plus the two slot values.
  logic [31:0] mq[$];
  logic        m_v1 = 1'b0, m_v2 = 1'b0;
  logic [31:0] m_i1 = 32'h0, m_i2 = 32'h0;
  int unsigned m_pair = 0, m_single = 0;

  wire [70:0] dut_vec = {in_ready, count, out_valid_1, out_valid_2, out_instr_1, out_instr_2};

  function automatic logic [70:0] exp_vec();
    logic rdy;
    rdy = (mq.size() <= DEPTH - 2);
    return {rdy, 4'(mq.size()), m_v1, m_v2, m_i1, m_i2};
  endfunction

  function automatic bit ref_pair(input logic [31:0] h, input logic [31:0] n);
    logic [6:0] oh, on;
    logic [4:0] rdh;
    bit h_wr, n_wr, n_r1, n_r2;
    oh   = h[6:0];
    on   = n[6:0];
    rdh  = h[11:7];
    h_wr = oh inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    n_wr = on inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1100111};
    n_r1 = !(on inside {7'b0110111, 7'b0010111, 7'b1101111});
    n_r2 = on inside {7'b0110011, 7'b0100011, 7'b1100011};
    if (h_wr && rdh != 0 && ((n_r1 && n[19:15] == rdh) || (n_r2 && n[24:20] == rdh))) return 0;
    if (h_wr && n_wr && rdh != 0 && rdh == n[11:7]) return 0;
    if ((oh inside {7'b0000011, 7'b0100011}) && (on inside {7'b0000011, 7'b0100011})) return 0;
    if (oh inside {7'b1100011, 7'b1101111, 7'b1100111}) return 0;
    return 1;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] op;
    case ($urandom_range(0, 9))
      0: op = 7'b0110011;  1: op = 7'b0010011;  2: op = 7'b0000011;
      3: op = 7'b0100011;  4: op = 7'b1100011;  5: op = 7'b1101111;
      6: op = 7'b1100111;  7: op = 7'b0110111;  8: op = 7'b0010111;
      default: op = 7'b0001111;
    endcase
    return {7'($urandom), 5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
            3'($urandom), 5'($urandom_range(0, 3)), op};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_v1 = 0; m_v2 = 0; m_i1 = 0; m_i2 = 0;
    m_pair = 0; m_single = 0;
  endfunction

  // Drive one cycle of inputs, advance the model, sample #1 after the edge.
  task automatic step(input bit v1, input bit v2, input logic [31:0] a, input logic [31:0] b,
                      input bit st, input bit fl);
    bit rdy;
    @(negedge clk);
    in_valid_1 = v1; in_valid_2 = v2; in_instr_1 = a; in_instr_2 = b;
    stall = st; flush = fl;
    rdy = (mq.size() <= DEPTH - 2);
    if (fl) begin
      mq.delete();
      m_v1 = 0; m_v2 = 0; m_i1 = 0; m_i2 = 0;
      m_pair = 0; m_single = 0;
    end else begin
      if (!st) begin
        m_v1 = 0; m_v2 = 0; m_i1 = 0; m_i2 = 0;
        if (mq.size() > 0) begin
          m_v1 = 1; m_i1 = mq.pop_front();
          if (mq.size() > 0 && ref_pair(m_i1, mq[0])) begin
            m_v2 = 1; m_i2 = mq.pop_front();
            m_pair++;
          end else begin
            m_single++;
          end
        end
      end
      if (rdy && v1) begin
        mq.push_back(a);
        if (v2) mq.push_back(b);
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #1 reset = 1'b0;
    #1;
    nvec++;
    if (dut_vec !== {1'b1, 4'h0, 1'b0, 1'b0, 64'h0}) begin
      nfail++; $display("FAIL reset_state: got %h want %h", dut_vec, {1'b1, 4'h0, 1'b0, 1'b0, 64'h0});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_pair();
    step(1, 1, 32'h002081B3, 32'h00838333, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, out_valid_2, out_instr_1, out_instr_2, count} !==
        {1'b1, 1'b1, 32'h002081B3, 32'h00838333, 4'h0}) begin
      nfail++; $display("FAIL pair_issue: got %b%b %h %h c=%0d", out_valid_1, out_valid_2, out_instr_1, out_instr_2, count);
    end
    // Back-to-back independent pairs sustain two per cycle.
    for (int i = 0; i < 4; i++) begin
      step(1, 1, 32'h002081B3, 32'h00838333, 0, 0);
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nfail++; $display("FAIL back_to_back: got %h want %h", dut_vec, exp_vec());
      end
    end
    idle(1);
    nvec++;
    if ({out_valid_1, out_valid_2} !== 2'b11) begin
      nfail++; $display("FAIL back_to_back_last: got %b want 11", {out_valid_1, out_valid_2});
    end
    idle(1);
  endtask

  task automatic test_raw();
    step(1, 1, 32'h002081B3, 32'h404182B3, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, out_valid_2, out_instr_1, out_instr_2} !== {1'b1, 1'b0, 32'h002081B3, 32'h0}) begin
      nfail++; $display("FAIL raw_first: got %b%b %h %h", out_valid_1, out_valid_2, out_instr_1, out_instr_2);
    end
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, out_valid_2, out_instr_1} !== {1'b1, 1'b0, 32'h404182B3}) begin
      nfail++; $display("FAIL raw_second: got %b%b %h want 10 404182b3", out_valid_1, out_valid_2, out_instr_1);
    end
  endtask

  task automatic test_mem();
    step(1, 1, 32'h0000A503, 32'h0020A023, 0, 0);
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, out_valid_2, out_instr_1} !== {1'b1, 1'b0, 32'h0000A503}) begin
      nfail++; $display("FAIL mem_first: got %b%b %h", out_valid_1, out_valid_2, out_instr_1);
    end
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, out_valid_2, out_instr_1} !== {1'b1, 1'b0, 32'h0020A023}) begin
      nfail++; $display("FAIL mem_second: got %b%b %h", out_valid_1, out_valid_2, out_instr_1);
    end
    idle(1);
  endtask

  task automatic test_full();
    idle(4);
    for (int i = 0; i < 3; i++) step(1, 1, rand_instr(), rand_instr(), 1, 0);
    nvec++;
    if ({in_ready, count} !== {1'b1, 4'd6}) begin
      nfail++; $display("FAIL full_six: got rdy=%b cnt=%0d want 1/6", in_ready, count);
    end
    step(1, 0, rand_instr(), 0, 1, 0);
    nvec++;
    if ({in_ready, count} !== {1'b0, 4'd7}) begin
      nfail++; $display("FAIL full_seven: got rdy=%b cnt=%0d want 0/7", in_ready, count);
    end
    step(1, 1, rand_instr(), rand_instr(), 1, 0);
    nvec++;
    if (count !== 4'd7) begin
      nfail++; $display("FAIL full_drop7: got cnt=%0d want 7", count);
    end
    step(0, 0, 0, 0, 1, 1);
    // Advance the pointers so the next fill straddles the wrap.
    for (int i = 0; i < 3; i++) step(1, 0, rand_instr(), 0, 0, 0);
    idle(3);
    for (int i = 0; i < 4; i++) step(1, 1, rand_instr(), rand_instr(), 1, 0);
    step(1, 1, rand_instr(), rand_instr(), 1, 0);
    nvec++;
    if ({in_ready, count} !== {1'b0, 4'd8}) begin
      nfail++; $display("FAIL full_eight: got rdy=%b cnt=%0d want 0/8", in_ready, count);
    end
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 0, 0, 0, 0);
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nfail++; $display("FAIL drain_wrap: got %h want %h", dut_vec, exp_vec());
      end
    end
  endtask

  task automatic test_flush();
    idle(4);
    step(1, 1, rand_instr(), rand_instr(), 1, 0);
    step(1, 1, rand_instr(), rand_instr(), 1, 0);
    step(1, 0, rand_instr(), 0, 1, 0);
    nvec++;
    if (count !== 4'd5) begin
      nfail++; $display("FAIL flush_setup: got cnt=%0d want 5", count);
    end
    step(1, 0, 32'h00838333, 0, 1, 1);
    nvec++;
    if ({count, out_valid_1, out_valid_2, out_instr_1, out_instr_2} !== {4'd0, 1'b0, 1'b0, 64'h0}) begin
      nfail++; $display("FAIL flush_clear: got cnt=%0d v=%b%b %h %h", count, out_valid_1, out_valid_2, out_instr_1, out_instr_2);
    end
    step(0, 0, 0, 0, 0, 0);
    nvec++;
    if ({out_valid_1, count} !== {1'b0, 4'd0}) begin
      nfail++; $display("FAIL flush_drop: got v1=%b cnt=%0d want 0/0", out_valid_1, count);
    end
  endtask

  task automatic test_random();
    bit v1, v2, st, fl;
    for (int k = 0; k < 400; k++) begin
      v1 = ($urandom_range(0, 3) != 0);
      v2 = ($urandom_range(0, 1) != 0);
      st = ($urandom_range(0, 4) == 0);
      fl = ($urandom_range(0, 40) == 0);
      step(v1, v2, rand_instr(), rand_instr(), st, fl);
      nvec++;
      if (dut_vec !== exp_vec()) begin
        nfail++; $display("FAIL random[%0d]: got %h want %h", k, dut_vec, exp_vec());
      end
`ifdef DIQ_STATS_EN
      nvec++;
      if ({pair_cnt, single_cnt} !== {m_pair, m_single}) begin
        nfail++; $display("FAIL stats[%0d]: got %0d/%0d want %0d/%0d", k, pair_cnt, single_cnt, m_pair, m_single);
      end
`endif
    end
  endtask

  task automatic test_async_reset();
    step(1, 1, rand_instr(), rand_instr(), 0, 0);
    step(1, 1, rand_instr(), rand_instr(), 0, 0);
    in_valid_1 = 0; in_valid_2 = 0; stall = 0; flush = 0;
    #1 reset = 1'b0;
    #1;
    nvec++;
    if (dut_vec !== {1'b1, 4'h0, 1'b0, 1'b0, 64'h0}) begin
      nfail++; $display("FAIL async_reset: got %h want %h", dut_vec, {1'b1, 4'h0, 1'b0, 1'b0, 64'h0});
    end
    model_reset();
    @(negedge clk);
    reset = 1'b1;
    idle(1);
    nvec++;
    if (dut_vec !== exp_vec()) begin
      nfail++; $display("FAIL post_reset: got %h want %h", dut_vec, exp_vec());
    end
  endtask

  initial begin
    test_reset();
    test_pair();
    test_raw();
    test_mem();
    test_full();
    test_flush();
    test_random();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule

// File: doc/dual_issue_queue.md
# dual_issue_queue

Instruction buffer and pair-issue selector that feeds the two decode slots of the dual-issue pipeline, whose outputs ultimately land in the ID/EX register. Fetch pushes up to two instructions per cycle. Each cycle the block pops one or two instructions from the head into registered slot outputs. Slot 2 is filled only when the head pair is independent and structurally compatible.

## Interface
- DEPTH, 8, queue entries; power of two, ≥4
- clk  input  1  rising-edge clock
- reset  input  1  asynchronous, active-low reset
- in_valid_1  input  1  fetch instruction 1 valid
- in_valid_2  input  1  fetch instruction 2 valid; ignored unless in_valid_1
- in_instr_1  input  32  older fetched instruction
- in_instr_2  input  32  younger fetched instruction
- in_ready  output  1  at least 2 free entries (combinational from registered count)
- flush  input  1  synchronous queue and slot clear (branch redirect)
- stall  input  1  hold slot outputs, no pop (load-use / hazard)
- out_valid_1  output  1  slot 1 holds an instruction
- out_valid_2  output  1  slot 2 holds an instruction
- out_instr_1  output  32  slot 1 instruction; 32'h0 when invalid
- out_instr_2  output  32  slot 2 instruction; 32'h0 when invalid
- count  output  $clog2(DEPTH)+1  occupied entries

## Operation
- Push: on an edge with in_ready & in_valid_1, write instr_1 at tail. If in_valid_2 is also set, write instr_2 at tail+1. Tail advances by 1 or 2, wrapping modulo DEPTH.
- Pop, on an edge with !stall & !flush:
  - count==0: both slots are loaded invalid.
  - count≥1: slot 1 takes the head.
  - Slot 2 takes head+1 iff count≥2 and the pair is compatible. Otherwise slot 2 is loaded invalid.
- Pairing is blocked when any of the following holds:
  - RAW: head writes a register (opcode 0110011, 0010011, 0000011, 0110111, 0010111, 1101111, 1100111) with rd≠0, and head+1 reads that rd. rs1 is read by all opcodes except LUI, AUIPC and JAL. rs2 is read only by R, S and B types.
  - WAW: both write the same nonzero rd.
  - Both are memory ops (opcode 0000011 or 0100011).
  - Head is a control transfer (1100011, 1101111, 1100111).
- Field slices: rd=[11:7], rs1=[19:15], rs2=[24:20], opcode=[6:0].
- Stall: slots hold their values and nothing is popped. Pushes are still accepted.
- Flush: has priority over stall and push. Head, tail and count go to 0, both out_valid go to 0, out_instr go to 0, and same-cycle pushes are dropped.
- count update: count + pushed − popped. Simultaneous push and pop is legal. in_ready reflects the pre-edge count.

## Timing
- Reset (asynchronous assert): head=tail=count=0, out_valid_1/2=0, out_instr_1/2=0, in_ready=1. Deassertion is taken synchronously by the next edge.
- Latency: a push sampled at edge N can first appear in a slot after edge N+1.
- Throughput: 2 instructions/cycle when compatible pairs are continuous and there is no stall.
- Full: in_ready=0 when count>DEPTH−2. Pushes presented while in_ready=0 are dropped; fetch must hold them.
- Wrap: head and tail wrap at DEPTH. A pair may straddle the wrap boundary.

## Configuration
- DIQ_STATS_EN defined: adds outputs pair_cnt and single_cnt, each 32 bits.
  - pair_cnt increments on every pop of 2; single_cnt increments on every pop of 1.
  - Both reset to 0, are cleared by flush, and wrap at 2^32.
- DIQ_STATS_EN undefined: these ports and counters do not exist.

## Structure
- Shared package diq_pkg holds:
  - opcode localparams (OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC);
  - field slice helper functions (rd, rs1, rs2, opcode);
  - writes_rd / reads_rs1 / reads_rs2 helper functions.
- Sub-module diq_pair_check: combinational; inputs two instructions, output can_pair.
- Top level contains the storage array, pointers, count and slot registers.

## Test plan
- Push 0x002081B3 (add x3,x1,x2) and 0x00838333 (add x6,x7,x8) together, then idle → one edge later out_valid_1=out_valid_2=1 with those instructions, count=0.
- Push 0x002081B3 and 0x404182B3 (sub x5,x3,x4) → slot 1 = add with out_valid_2=0. Next cycle slot 1 = sub.
- Push 0x0000A503 (lw) and 0x0020A023 (sw) → issued singly on consecutive cycles.
- Fill with 8 pushes without popping, stall high → in_ready=0 once count reaches 7; further pushes dropped, count stays 8. Release stall → the queue drains and FIFO order is preserved across the wrap.
- With 5 entries queued and stall=1, assert flush with simultaneous in_valid_1 → count=0, out_valid_1/2=0, pushed instruction absent.
- Assert reset mid-stream → outputs zero immediately without a clock edge, in_ready=1.
